// File: rtl/cgra_in_loader_pkg.sv
// Shared types for the CGRA input loader.
// Lane word layout and FSM encodings used by the loader and its bench.
package cgra_loader_pkg;

    localparam int DEF_NUM_LANES = 16;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_CNT_W     = 16;
    localparam int LANE_W        = DEF_DATA_W + 1;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2
    } state_e;

    typedef struct packed {
        logic                  v;
        logic [DEF_DATA_W-1:0] data;
    } lane_word_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cgra_in_loader_if.sv
// Operand stream, accelerator handshake and lane bus of the loader.
// master = loader side, slave = core/CGRA side.
interface cgra_in_loader_if
    import cgra_loader_pkg::*;
#(
    parameter int NUM_LANES = DEF_NUM_LANES,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int CNT_W     = DEF_CNT_W
);

    logic                            s_valid;
    logic                            s_ready;
    logic [DATA_W-1:0]               s_data;
    logic                            s_last;
    logic                            flush;
    logic                            launch;
    logic                            acc_ready;
    logic                            acc_done;
    logic [NUM_LANES*(DATA_W+1)-1:0] ins_flat;
    logic [1:0]                      state_o;
    logic [CNT_W-1:0]                batch_cnt;

    modport master (
        input  s_valid,
        input  s_data,
        input  s_last,
        input  flush,
        input  acc_ready,
        input  acc_done,
        output s_ready,
        output launch,
        output ins_flat,
        output state_o,
        output batch_cnt
    );

    modport slave (
        output s_valid,
        output s_data,
        output s_last,
        output flush,
        output acc_ready,
        output acc_done,
        input  s_ready,
        input  launch,
        input  ins_flat,
        input  state_o,
        input  batch_cnt
    );

endinterface

// File: rtl/cgra_in_loader_lane_bank.sv
// Lane register bank: indexed write, synchronous clear,
// flattened read-out with the valid bits gated by show_v.
module cgra_lane_bank #(
    parameter int NUM_LANES = 16,
    parameter int DATA_W    = 32,
    parameter int IDX_W     = 4
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            we,
    input  logic [IDX_W-1:0]                widx,
    input  logic [DATA_W-1:0]               wdata,
    input  logic                            clr,
    input  logic                            show_v,
    output logic [NUM_LANES*(DATA_W+1)-1:0] ins_flat
);

    localparam int LW = DATA_W + 1;

    logic [DATA_W-1:0]    data_q [NUM_LANES];
    logic [NUM_LANES-1:0] v_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                data_q[i] <= '0;
            end
            v_q <= '0;
        end else if (clr) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                data_q[i] <= '0;
            end
            v_q <= '0;
        end else if (we) begin
            data_q[widx] <= wdata;
            v_q[widx]    <= 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_rd
        assign ins_flat[i*LW +: LW] = {v_q[i] & show_v, data_q[i]};
    end

endmodule

// File: rtl/cgra_in_loader.sv
// Producer side of the CGRA input lanes: gathers a batch of
// operand words, launches it, waits for completion, reloads.
module cgra_in_loader
    import cgra_loader_pkg::*;
#(
    parameter int NUM_LANES = DEF_NUM_LANES,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic              clock,
    input  logic              reset_n,
    cgra_in_loader_if.master  bus
);

    localparam int IDX_W = idx_w(NUM_LANES);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LANES - 1);

    localparam logic [1:0] ST_LOAD  = LOAD;
    localparam logic [1:0] ST_ISSUE = ISSUE;
    localparam logic [1:0] ST_BUSY  = BUSY;

    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             beat;
    logic             last_beat;
    logic             clr;

    // handshake outputs decode from state only
    assign bus.s_ready   = (state == ST_LOAD);
    assign bus.launch    = (state == ST_ISSUE);
    assign bus.state_o   = state;
    assign bus.batch_cnt = cnt;

    assign beat      = bus.s_valid && (state == ST_LOAD) && !bus.flush;
    assign last_beat = bus.s_last || (idx == LAST_IDX);

    assign clr = bus.flush
               || ((state == ST_BUSY) && bus.acc_done)
               || (state == 2'd3);

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        cnt_nx   = cnt;
        if (bus.flush) begin
            state_nx = ST_LOAD;
            idx_nx   = '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (beat) begin
                        if (last_beat) begin
                            idx_nx   = '0;
                            state_nx = ST_ISSUE;
                        end else begin
                            idx_nx = idx + 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (bus.acc_ready) begin
                        cnt_nx   = cnt + 1'b1;
                        state_nx = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (bus.acc_done) begin
                        state_nx = ST_LOAD;
                    end
                end
                default: begin
                    state_nx = ST_LOAD;
                    idx_nx   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_LOAD;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            cnt   <= cnt_nx;
        end
    end

    cgra_lane_bank #(
        .NUM_LANES (NUM_LANES),
        .DATA_W    (DATA_W),
        .IDX_W     (IDX_W)
    ) u_bank (
        .clock    (clock),
        .reset_n  (reset_n),
        .we       (beat),
        .widx     (idx),
        .wdata    (bus.s_data),
        .clr      (clr),
        .show_v   (bus.launch),
        .ins_flat (bus.ins_flat)
    );

endmodule

// File: doc/cgra_in_loader.md
Name: cgra_in_loader

Overview:
- Producer side of the 16-lane CGRA input interface: accepts a CPU-side stream of 32-bit operand words and scatters them in order into 16 lane registers.
- Launches the batch onto the lanes as 33-bit words {valid, data}, waits for accelerator acceptance and completion, then reloads.
- Sits between the core's accelerator-command path and the CGRA array. Its lane outputs are the words the simulation-side input monitor samples.

Parameters:
- NUM_LANES, 16, number of CGRA input lanes (≥2, power of two not required)
- DATA_W, 32, payload width per lane; lane word width is DATA_W+1
- CNT_W, 16, width of the launched-batch counter

Ports:
- clock  input  1  single clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- s_valid  input  1  operand stream word valid
- s_ready  output  1  loader can accept an operand word
- s_data  input  DATA_W  operand payload
- s_last  input  1  word closes the batch early
- flush  input  1  synchronous abort; discard current batch
- launch  output  1  batch presented on lanes, awaiting acceptance
- acc_ready  input  1  CGRA accepts presented batch this cycle
- acc_done  input  1  single-cycle pulse: CGRA finished the batch
- ins_flat  output  NUM_LANES*(DATA_W+1)  lane i at bits [i*(DATA_W+1) +: DATA_W+1]; bit DATA_W of each lane word = lane valid
- state_o  output  2  current FSM state encoding
- batch_cnt  output  CNT_W  number of accepted launches, wraps

Behaviour:
- Reset (async, reset_n=0):
  - state=LOAD, fill index=0, all lane data=0, all lane valid bits=0, batch_cnt=0.
  - Outputs during and after reset: s_ready=1 (LOAD), launch=0, ins_flat=0, state_o=LOAD.
- FSM encodings: LOAD=0, ISSUE=1, BUSY=2; value 3 is unused and recovers to LOAD next cycle.
- LOAD:
  - s_ready=1.
  - On s_valid&&s_ready: lane[idx].data<=s_data, lane[idx].v<=1, idx<=idx+1.
  - If idx==NUM_LANES-1 or s_last=1 on that beat: go ISSUE next cycle, idx<=0.
  - acc_done is ignored.
- ISSUE:
  - s_ready=0, launch=1.
  - ins lane word = {lane.v, lane.data}; lanes not written this batch read valid=0, data=0.
  - Lanes stay stable while launch && !acc_ready.
  - On acc_ready: batch_cnt++ (wraps 2^CNT_W-1 -> 0), go BUSY.
  - Lane word bit DATA_W is forced 0 in every state except ISSUE; data bits show register contents in all states.
- BUSY:
  - s_ready=0, launch=0.
  - On acc_done: clear all lane data and valid bits, go LOAD.
  - acc_ready is ignored.
- flush=1 has priority over every other event in every state: clear lanes and idx, go LOAD next cycle.
  - batch_cnt is not incremented, even if acc_ready is high in the same cycle.
  - A stream beat coincident with flush is dropped (not written).
- Latency:
  - Last accepted beat -> launch=1 on the following cycle.
  - acc_done -> s_ready=1 on the following cycle.
  - Minimum batch of 1 word: LOAD(1 beat) -> ISSUE -> BUSY -> LOAD.
- s_last on beat NUM_LANES-1 behaves identically to a full batch.
- No combinational path from s_valid to s_ready, or from acc_ready to launch; both are decoded from state only.
- Reset asserted mid-ISSUE or mid-BUSY: outputs return to reset values immediately (async). No partial batch survives.

Decomposition:
- Package cgra_loader_pkg:
  - state enum (LOAD/ISSUE/BUSY)
  - NUM_LANES/DATA_W defaults
  - lane_word_t packed struct {logic v; logic [DATA_W-1:0] data}
  - LANE_W localparam = DATA_W+1
- Sub-module cgra_lane_bank:
  - Holds lane registers and valid bits.
  - Write-enable + index port, synchronous clear, flattened read-out with valid masking input.
- FSM and counters stay in the top.

Test Plan:
- Full batch: 16 beats s_data=0x100+i, no s_last, acc_ready=1 at first launch -> launch asserted 1 cycle after beat 15; lane i = {1, 0x100+i}; batch_cnt=1; BUSY until acc_done; s_ready=1 the cycle after acc_done; ins_flat=0.
- Short batch: 3 beats 0xA,0xB,0xC with s_last on third -> ISSUE; lanes 0..2 valid with those data; lanes 3..15 = 33'h0.
- Backpressure: acc_ready held 0 for 5 cycles in ISSUE -> launch=1 and ins_flat unchanged all 5 cycles; s_ready=0; batch_cnt increments only on the acc_ready cycle.
- Flush races:
  - Flush during LOAD after 7 beats -> next cycle lanes cleared, idx=0; next 16 beats land in lanes 0..15.
  - Flush coincident with acc_ready in ISSUE -> LOAD, batch_cnt unchanged.
- Counter wrap: CNT_W=4, run 17 one-word batches -> batch_cnt reads 1; each acc_done received in LOAD/ISSUE is ignored.
- Async reset asserted mid-BUSY (not clock-aligned) -> launch=0, ins_flat=0, state_o=0, s_ready=1 immediately; first post-reset beat lands in lane 0.
